data_mem_burst: RTL and testbench

// - Parametrised backing data memory for the RISC-V data cache: multi-cycle line refill reads, word writes with byte strobes.
// - Sits behind the D-cache controller; a read returns a whole aligned line, a write updates one word (write-through path).
// - Programmable read/write latency; explicit req/ready/busy handshake replaces miss-driven counting.

---
 rtl/data_mem_burst_pkg.sv | 17 +
 rtl/data_mem_burst_mem_lat_ctrl.sv | 65 ++++++
 rtl/data_mem_burst.sv | 87 ++++++++
 tb/tb_data_mem_burst.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_burst_pkg.sv
// Shared definitions for the burst data memory: FSM encodings, default geometry
// shared with the D-cache, and a small constant helper.
package data_mem_burst_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_LINE_WORDS = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/data_mem_burst_mem_lat_ctrl.sv
// Latency controller: single-outstanding FSM plus down-counter that produces
// busy, the one-cycle ready pulse and the read/write commit strobes.
import data_mem_burst_pkg::*;

module mem_lat_ctrl #(
  parameter int RD_LAT = 3,
  parameter int WR_LAT = 3
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       rd_en,
  input  logic       wr_en,
  output logic [1:0] state,
  output logic       busy,
  output logic       ready,
  output logic       rd_commit,
  output logic       wr_commit
);

  localparam int CNT_W = $clog2(max_int(RD_LAT, WR_LAT) + 1);

  logic [CNT_W-1:0] cnt;

  // Commit fires on the edge that ends the wait, together with the ready pulse.
  assign rd_commit = (state == ST_RD_WAIT) && (cnt == '0);
  assign wr_commit = (state == ST_WR_WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_en) begin
            state <= ST_RD_WAIT;
            cnt   <= CNT_W'(RD_LAT - 1);
            busy  <= 1'b1;
          end else if (wr_en) begin
            state <= ST_WR_WAIT;
            cnt   <= CNT_W'(WR_LAT - 1);
            busy  <= 1'b1;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_mem_burst.sv
// Backing data memory for the D-cache: whole-line refill reads and byte-strobed
// word writes, each completing after a programmable latency.
import data_mem_burst_pkg::*;

module data_mem_burst #(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int RD_LAT     = 3,
  parameter int WR_LAT     = 3
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         rd_en,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  output logic [LINE_WORDS*DATA_W-1:0] rline,
  output logic                         ready,
  output logic                         busy
);

  localparam int LINE_OFF_W = $clog2(LINE_WORDS);
  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int NBYTES     = DATA_W / 8;

  logic [DATA_W-1:0]            mem [DEPTH];
  logic [1:0]                   state;
  logic                         rd_commit;
  logic                         wr_commit;
  logic                         rd_acc;
  logic                         wr_acc;
  logic [ADDR_W-LINE_OFF_W-1:0] rd_base;
  logic [ADDR_W-1:0]            waddr;
  logic [DATA_W-1:0]            wdata_q;
  logic [NBYTES-1:0]            wstrb_q;

  mem_lat_ctrl #(
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) u_ctrl (
    .clk       (clk),
    .RST       (RST),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .state     (state),
    .busy      (busy),
    .ready     (ready),
    .rd_commit (rd_commit),
    .wr_commit (wr_commit)
  );

  // Read has priority; a simultaneous write is dropped and must be re-presented.
  assign rd_acc = (state == ST_IDLE) && rd_en;
  assign wr_acc = (state == ST_IDLE) && wr_en && !rd_en;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rd_base <= '0;
      waddr   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rline   <= '0;
    end else begin
      if (rd_acc) rd_base <= addr[ADDR_W-1:LINE_OFF_W];
      if (wr_acc) begin
        waddr   <= addr;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (rd_commit) begin
        for (int k = 0; k < LINE_WORDS; k++)
          rline[k*DATA_W +: DATA_W] <= mem[{rd_base, LINE_OFF_W'(k)}];
      end
    end
  end

  // Storage is never reset; an aborted write never reaches the commit strobe.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < NBYTES; b++)
        if (wstrb_q[b]) mem[waddr][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_burst.sv
// Self-checking bench: two instances (RD/WR latency 3/3 and 1/5) against a word
// model, with a per-instance expected-rline queue popped on every ready pulse.
module tb_data_mem_burst;

  localparam int RD_LAT_A = 3;
  localparam int WR_LAT_A = 3;
  localparam int RD_LAT_B = 1;
  localparam int WR_LAT_B = 5;

  logic         clk;
  logic         RST;
  logic         rd_a, wr_a, rd_b, wr_b;
  logic [9:0]   addr_a, addr_b;
  logic [31:0]  wdata_a, wdata_b;
  logic [3:0]   wstrb_a, wstrb_b;
  logic [127:0] rline_a, rline_b;
  logic         ready_a, ready_b, busy_a, busy_b;

  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];
  logic [31:0]  mdl [2][1024];
  logic [127:0] last_line [2];
  int           n_checks = 0;
  int           n_fail   = 0;

  data_mem_burst #(.RD_LAT(RD_LAT_A), .WR_LAT(WR_LAT_A)) dut_a (
    .clk(clk), .RST(RST), .rd_en(rd_a), .wr_en(wr_a), .addr(addr_a),
    .wdata(wdata_a), .wstrb(wstrb_a), .rline(rline_a), .ready(ready_a), .busy(busy_a)
  );

  data_mem_burst #(.RD_LAT(RD_LAT_B), .WR_LAT(WR_LAT_B)) dut_b (
    .clk(clk), .RST(RST), .rd_en(rd_b), .wr_en(wr_b), .addr(addr_b),
    .wdata(wdata_b), .wstrb(wstrb_b), .rline(rline_b), .ready(ready_b), .busy(busy_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic get_ready(input int w);
    return (w == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic [127:0] model_line(input int w, input logic [9:0] a);
    logic [127:0] l;
    logic [9:0]   idx;
    for (int k = 0; k < 4; k++) begin
      idx = {a[9:2], 2'(k)};
      l[k*32 +: 32] = mdl[w][idx];
    end
    return l;
  endfunction

  // Scoreboard: every ready pulse must match the oldest expected rline.
  always @(negedge clk) begin
    if (ready_a) begin
      if (exp_q0.size() == 0) check("spurious_ready_a", ready_a, 1'b0);
      else check("rline_a", rline_a, exp_q0.pop_front());
    end
    if (ready_b) begin
      if (exp_q1.size() == 0) check("spurious_ready_b", ready_b, 1'b0);
      else check("rline_b", rline_b, exp_q1.pop_front());
    end
  end

  // Driver tasks
  task automatic drive(input int w, input logic rd, input logic wr, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (w == 0) begin
      rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d; wstrb_a = s;
    end else begin
      rd_b = rd; wr_b = wr; addr_b = a; wdata_b = d; wstrb_b = s;
    end
  endtask

  task automatic do_req(input int w, input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit poke);
    int lat;
    int cyc;
    @(negedge clk);
    drive(w, rd, wr, a, d, s);
    if (rd) begin
      last_line[w] = model_line(w, a);
      lat = (w == 0) ? RD_LAT_A : RD_LAT_B;
    end else begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[w][a][b*8 +: 8] = d[b*8 +: 8];
      lat = (w == 0) ? WR_LAT_A : WR_LAT_B;
    end
    if (w == 0) exp_q0.push_back(last_line[0]);
    else        exp_q1.push_back(last_line[1]);
    @(negedge clk);
    cyc = 1;
    drive(w, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    check($sformatf("busy_on_%0d", w), get_busy(w), 1'b1);
    if (poke) begin
      drive(w, 1'b1, 1'b1, 10'h100, 32'h0BAD0BAD, 4'hF);
      @(negedge clk);
      cyc++;
      drive(w, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    end
    while (!get_ready(w) && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency_%0d", w), cyc, lat + 1);
    check($sformatf("busy_off_%0d", w), get_busy(w), 1'b0);
    @(negedge clk);
    check($sformatf("ready_pulse_%0d", w), get_ready(w), 1'b0);
  endtask

  logic [9:0] words [8];

  initial begin
    words = '{10'h004, 10'h005, 10'h006, 10'h007, 10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF};
    last_line[0] = '0;
    last_line[1] = '0;
    drive(0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    RST = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_a", ready_a, 1'b0);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_rline_a", rline_a, 128'h0);
    check("rst_rline_b", rline_b, 128'h0);
    RST = 1'b1;

    // Preload the lines under test with full-word writes.
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++)
        do_req(w, 1'b0, 1'b1, words[i], (i == 1) ? 32'h11223344 : $urandom, 4'hF, 1'b0);

    for (int w = 0; w < 2; w++) begin
      do_req(w, 1'b1, 1'b0, 10'h006, 32'h0, 4'h0, 1'b0);
      do_req(w, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'b0011, 1'b0);
      do_req(w, 1'b1, 1'b0, 10'h004, 32'h0, 4'h0, 1'b0);
      check($sformatf("merged_word_%0d", w), (w == 0) ? rline_a[63:32] : rline_b[63:32], 32'h1122BEEF);
    end

    // Simultaneous read and write: the write must be dropped.
    do_req(0, 1'b1, 1'b1, 10'h007, 32'h00000000, 4'hF, 1'b0);
    do_req(0, 1'b1, 1'b0, 10'h004, 32'h0, 4'h0, 1'b0);

    // Extra requests during the read wait must be ignored.
    do_req(0, 1'b1, 1'b0, 10'h3FD, 32'h0, 4'h0, 1'b1);
    repeat (4) @(negedge clk);

    do_req(0, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0, 1'b0);
    do_req(1, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0, 1'b0);

    // Reset in the middle of a write: nothing committed, outputs cleared at once.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 10'h005, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("mid_wr_busy", busy_a, 1'b1);
    RST = 1'b0;
    #1;
    check("abort_ready", ready_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_rline_a", rline_a, 128'h0);
    check("abort_rline_b", rline_b, 128'h0);
    last_line[0] = '0;
    last_line[1] = '0;
    @(negedge clk);
    RST = 1'b1;
    do_req(0, 1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b0);
    check("after_abort_word1", rline_a[63:32], 32'h1122BEEF);
    do_req(1, 1'b1, 1'b0, 10'h004, 32'h0, 4'h0, 1'b0);

    // Random mix of strobed writes and reads over the preloaded lines.
    for (int i = 0; i < 12; i++) begin
      int w;
      w = $urandom_range(1, 0);
      if ($urandom_range(1, 0) == 1)
        do_req(w, 1'b0, 1'b1, words[$urandom_range(7, 0)], $urandom, 4'($urandom_range(15, 0)), 1'b0);
      else
        do_req(w, 1'b1, 1'b0, words[$urandom_range(7, 0)], 32'h0, 4'h0, 1'b0);
    end

    repeat (8) @(negedge clk);
    check("queue_empty_a", exp_q0.size(), 0);
    check("queue_empty_b", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
